// File: rtl/mips_register_file.sv
// MIPS general-purpose register file: 2 combinational read ports and 1 write port.
// $0 is hard-wired to zero. A read of the register being written in the same
// cycle returns the incoming write data. An active-low reset clears every
// entry immediately and forces both read ports to zero while it is held.
module mips_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  reg_write,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic                  write_en;

    // A write only counts when it is enabled and does not target $0.
    // Reset is not part of this term: the read-side logic checks rst_n first,
    // so reset already blocks the bypass.
    assign write_en = reg_write && (write_reg != '0);

    // Storage: asynchronous clear, then one write per rising edge.
    // Entry 0 is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en) begin
            regs[write_reg] <= write_data;
        end
    end

    // Read port 1: forced to zero under reset or for $0.
    // A matching same-cycle write is bypassed through.
    always_comb begin
        read_data1 = '0;
        if (rst_n && (read_reg1 != '0)) begin
            if (write_en && (write_reg == read_reg1)) begin
                read_data1 = write_data;
            end else begin
                read_data1 = regs[read_reg1];
            end
        end
    end

    // Read port 2: same behaviour as port 1.
    always_comb begin
        read_data2 = '0;
        if (rst_n && (read_reg2 != '0)) begin
            if (write_en && (write_reg == read_reg2)) begin
                read_data2 = write_data;
            end else begin
                read_data2 = regs[read_reg2];
            end
        end
    end

endmodule

// File: tb/tb_mips_register_file.sv
// Scoreboard bench for mips_register_file.
// The stimulus process drives each cycle's inputs shortly after the rising edge
// and queues the read values it expects from a simple array model.
// The monitor samples both ports on the falling edge and pops one queued
// expectation for each observation.
module tb_mips_register_file;

    logic        clk;
    logic        rst_n;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        reg_write;
    logic [31:0] read_data1;
    logic [31:0] read_data2;

    mips_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .write_reg  (write_reg),
        .write_data (write_data),
        .reg_write  (reg_write),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    typedef struct {
        string       name;
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [32];
    logic        pend;
    logic [4:0]  pend_idx;
    logic [31:0] pend_data;
    int          tests;
    int          fails;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural view of a read: reset reads zero, $0 reads zero,
    // otherwise the newest value (including this cycle's write).
    function automatic logic [31:0] expv(input logic [4:0] idx);
        if (!rst_n || idx == 5'd0) return 32'h0;
        if (reg_write && write_reg == idx) return write_data;
        return model[idx];
    endfunction

    function automatic void clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endfunction

    // One cycle of stimulus. The write is committed to the model at the next edge.
    task automatic drive(input logic r, input logic we, input logic [4:0] wr,
                         input logic [31:0] wd, input logic [4:0] r1,
                         input logic [4:0] r2, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        if (pend) model[pend_idx] = pend_data;
        pend       = 1'b0;
        rst_n      = r;
        reg_write  = we;
        write_reg  = wr;
        write_data = wd;
        read_reg1  = r1;
        read_reg2  = r2;
        if (!r) clear_model();
        e.name = nm;
        e.e1   = expv(r1);
        e.e2   = expv(r2);
        sb.push_back(e);
        if (r && we && wr != 5'd0) begin
            pend      = 1'b1;
            pend_idx  = wr;
            pend_data = wd;
        end
    endtask

    // Reset drops between edges. The reads must clear before any further edge.
    task automatic mid_cycle_reset(input logic [4:0] r1, input logic [4:0] r2);
        exp_t e;
        @(posedge clk);
        #1;
        if (pend) model[pend_idx] = pend_data;
        pend      = 1'b0;
        reg_write = 1'b0;
        read_reg1 = r1;
        read_reg2 = r2;
        #2;
        rst_n = 1'b0;
        clear_model();
        e.name = "mid_reset";
        e.e1   = 32'h0;
        e.e2   = 32'h0;
        sb.push_back(e);
    endtask

    // Monitor: compare the live ports against each expectation due this cycle.
    initial begin
        exp_t e;
        tests = 0;
        fails = 0;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                tests++;
                if (read_data1 !== e.e1) begin
                    fails++;
                    $display("FAIL %s port1 rr1=%0d got=%h want=%h", e.name, read_reg1, read_data1, e.e1);
                end
                tests++;
                if (read_data2 !== e.e2) begin
                    fails++;
                    $display("FAIL %s port2 rr2=%0d got=%h want=%h", e.name, read_reg2, read_data2, e.e2);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0]  wr;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] wd;
        rst_n = 1'b0;
        reg_write = 1'b0;
        write_reg = '0;
        write_data = '0;
        read_reg1 = '0;
        read_reg2 = '0;
        pend = 1'b0;
        pend_idx = '0;
        pend_data = '0;
        clear_model();

        // Sweep every index on both ports while reset is held,
        // with writes attempted and bypass candidates present.
        for (int i = 0; i < 32; i++)
            drive(1'b0, 1'b1, 5'(i), 32'hA5A5_0000 + i, 5'(i), 5'(31 - i), "in_reset");

        // Sweep again after release: every entry must still read zero.
        for (int i = 0; i < 32; i++)
            drive(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), "post_reset");

        // Shifter operands
        drive(1'b1, 1'b1, 5'd8, 32'h8000_0000, 5'd0, 5'd8, "wr8");
        drive(1'b1, 1'b1, 5'd9, 32'h0000_0004, 5'd9, 5'd8, "wr9");
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd8, "shift_ops");

        // Writes to $0 are discarded, with and without the same-cycle bypass.
        drive(1'b1, 1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0, "zero_bypass");
        drive(1'b1, 1'b0, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd9, "zero_after");

        // Same-cycle write-through on both ports, then the stored value afterwards
        drive(1'b1, 1'b1, 5'd5, 32'h1111_1111, 5'd1, 5'd2, "wr5a");
        drive(1'b1, 1'b1, 5'd5, 32'h2222_2222, 5'd5, 5'd5, "bypass5");
        drive(1'b1, 1'b0, 5'd5, 32'h3333_3333, 5'd5, 5'd5, "after5");

        // Random traffic. Reads are biased to hit the write index.
        for (int n = 0; n < 200; n++) begin
            wr = 5'($urandom_range(0, 31));
            wd = $urandom;
            r1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            drive(1'b1, 1'($urandom_range(0, 1)), wr, wd, r1, r2, "random");
        end

        // Write-disabled cycles with noisy write_reg and write_data
        for (int n = 0; n < 100; n++)
            drive(1'b1, 1'b0, 5'($urandom_range(0, 31)), $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), "we_off");
        for (int i = 0; i < 32; i++)
            drive(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), "hold_sweep");

        // Load value = index, then reset mid-cycle
        for (int i = 1; i < 32; i++)
            drive(1'b1, 1'b1, 5'(i), 32'(i), 5'(i), 5'(i - 1), "load_idx");
        mid_cycle_reset(5'd7, 5'd31);
        for (int i = 0; i < 32; i++)
            drive(1'b0, 1'b1, 5'd3, 32'hFFFF_FFFF, 5'(i), 5'(31 - i), "held_reset");

        // Release, then write on the first edge
        drive(1'b1, 1'b1, 5'd3, 32'h0000_0007, 5'd3, 5'd4, "first_write");
        for (int i = 0; i < 32; i++)
            drive(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), "final_sweep");

        repeat (2) @(posedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mips_register_file.md
MIPS_REGISTER_FILE -- requirements
Module: mips_register_file

Interface
- REQ-001: Parameter DATA_WIDTH, default 32, register and data-port width in bits.
- REQ-002: Parameter ADDR_WIDTH, default 5, register-index width; depth is 2^ADDR_WIDTH (32).
- REQ-003: clk  input  1  single clock; all register writes on its rising edge.
- REQ-004: rst_n  input  1  reset, asynchronous, active-low.
- REQ-005: read_reg1  input  5  index for port 1 (rs; supplies shift amount for variable shifts).
- REQ-006: read_reg2  input  5  index for port 2 (rt; supplies value to be shifted).
- REQ-007: write_reg  input  5  destination index.
- REQ-008: write_data  input  32  data to write (ALU/shifter result or memory data).
- REQ-009: reg_write  input  1  write enable, active-high.
- REQ-010: read_data1  output  32  contents selected by read_reg1.
- REQ-011: read_data2  output  32  contents selected by read_reg2.

Function
- REQ-012: Storage SHALL be 32 entries of 32 bits, indices 0..31.
- REQ-013: On rising clk with rst_n=1, reg_write=1 and write_reg!=0, entry[write_reg] SHALL take write_data.
- REQ-014: With reg_write=0, no entry SHALL change.
- REQ-015: Entry 0 SHALL always read 0x00000000; writes to index 0 SHALL be discarded, with no side effect on any other entry.
- REQ-016: Read ports SHALL be combinational, zero-cycle latency, reflecting stored contents after any settling.
- REQ-017: Read-during-write: when reg_write=1, write_reg!=0 and read_regN==write_reg, read_dataN SHALL return write_data combinationally (write-through bypass), same cycle.
- REQ-018: Bypass SHALL NOT apply when write_reg=0; read of index 0 returns 0 regardless.
- REQ-019: Both ports SHALL be able to read the same index at once; both return identical values.
- REQ-020: Index inputs use all 5 bits; no out-of-range index exists, no wrap logic needed.
- REQ-021: Exactly one write per cycle; the last write to an index before a read wins.
- REQ-022: X or Z on write_reg while reg_write=0 SHALL NOT corrupt any entry.

Reset
- REQ-023: rst_n=0 SHALL clear all 32 entries to 0x00000000 immediately, without waiting for a clk edge.
- REQ-024: While rst_n=0, writes SHALL be blocked and both read ports SHALL output 0x00000000, bypass included.
- REQ-025: Reset asserted mid-write (same cycle as a reg_write edge) SHALL win; the entry reads 0 afterward.
- REQ-026: Writes SHALL resume at the first rising clk edge after rst_n deasserts; no extra wait cycles.

Verification
- REQ-027: Reset, then read every index on both ports -> all reads 0x00000000.
- REQ-028: Write $8=0x80000000, then $9=0x00000004; read_reg1=9, read_reg2=8 -> read_data1=0x00000004, read_data2=0x80000000 (shifter operands giving srl result 0x08000000).
- REQ-029: reg_write=1, write_reg=0, write_data=0xDEADBEEF; then read_reg1=0 -> 0x00000000, including the same-cycle bypass case.
- REQ-030: $5 holds 0x11111111; same cycle write $5=0x22222222 with read_reg1=read_reg2=5 -> both ports 0x22222222 before the edge, and still 0x22222222 after it.
- REQ-031: Load $1..$31 with value=index; drop rst_n mid-cycle between edges -> all reads 0 at once; after release, write $3=0x7 -> read 0x7, others 0.
- REQ-032: reg_write=0 with write_data and write_reg toggling randomly over 100 cycles -> all previously written values unchanged.
